mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates a single shared memory port between the core's instruction-fetch side and data (load/store) side. Each requester issues a level request held until a one-cycle response. The block sequences one outstanding memory transaction at a time and returns read data to the winner. It gives the data side priority with a starvation bound for fetch, and keeps per-core performance counters printed on `report`. It sits between the fetch/memory stages and the single-ported main memory model.

## Interface
- `CORE`, 0, core ID used in report messages
- `DATA_WIDTH`, 32, data word width
- `ADDRESS_BITS`, 20, word address width
- `STARVE_LIMIT`, 4, consecutive D grants allowed while I waits (1..15)
- `TIMEOUT`, 64, max WAIT cycles before abort (2..255)

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `i_req`  in  1  fetch request (level)
- `i_addr`  in  ADDRESS_BITS  fetch address
- `i_valid`  out  1  fetch response, 1-cycle pulse
- `i_data`  out  DATA_WIDTH  fetched word, valid with `i_valid`
- `d_load`  in  1  load request (level)
- `d_store`  in  1  store request (level)
- `d_addr`  in  ADDRESS_BITS  data address
- `d_store_data`  in  DATA_WIDTH  store data
- `d_valid`  out  1  data response, 1-cycle pulse
- `d_data`  out  DATA_WIDTH  load data, valid with `d_valid`; 0 for stores
- `mem_read`  out  1  memory read command, 1-cycle pulse
- `mem_write`  out  1  memory write command, 1-cycle pulse
- `mem_address`  out  ADDRESS_BITS  held for whole transaction
- `mem_write_data`  out  DATA_WIDTH  held for whole transaction
- `mem_read_data`  in  DATA_WIDTH  sampled when `mem_valid`=1
- `mem_valid`  in  1  memory completion (reads and writes)
- `error`  out  1  sticky: timeout or `d_load`&`d_store` both seen
- `report`  in  1  print counters

## Operation
- FSM states: IDLE, WAIT_I, WAIT_D, RESP.
- IDLE: if D request (`d_load|d_store`) and (`!i_req` or `starve_cnt` < STARVE_LIMIT) -> WAIT_D; else if `i_req` -> WAIT_I; else stay. On grant, latch address, data, and op.
- `d_load`&`d_store` together: treated as a store; `error` set.
- `starve_cnt` (4 bits): +1 on each D grant while `i_req`=1; cleared on I grant or when `i_req`=0 in IDLE. At the limit, I wins the next IDLE arbitration.
- WAIT_x, first cycle: `mem_read` (I, load) or `mem_write` (store) pulses. `mem_valid` is ignored in this cycle.
- WAIT_x, later cycles: `mem_valid`=1 -> capture `mem_read_data` -> RESP. A `wait_cnt` reaching TIMEOUT -> RESP with data 0 and `error` set.
- RESP: exactly one of `i_valid`/`d_valid` high for one cycle, with data -> IDLE. Requesters update their request by the next edge; IDLE samples requests only after RESP.
- `mem_valid` in IDLE/RESP: ignored.
- Counters (32-bit, saturating at all-ones): `i_grants`, `d_grants`, `i_wait_cycles` (cycles with `i_req`=1 and state not WAIT_I/RESP-for-I).
- `report`=1 in a cycle: `$display` of CORE and the three counters.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, `error` 0.
- Request in IDLE cycle 0 -> command pulse cycle 1 -> earliest accepted `mem_valid` cycle 2 -> response pulse cycle 3. Minimum latency is 3 cycles; back-to-back throughput is 1 transaction per 4 cycles at minimum memory latency.
- Reset mid-transaction: immediate return to IDLE, no response issued. Counters and `error` cleared. A stale `mem_valid` arriving afterward is ignored.
- `mem_address`/`mem_write_data` stay stable from the command cycle through the `mem_valid` cycle; they hold their last value otherwise.

## Structure
- Shared package: FSM state encoding (2 bits) and the counter width constant.
- One sub-module is natural: `sat_counter` (parameterised width, increment enable, synchronous clear), instantiated three times.

## Test plan
- `i_req`=1, `i_addr`=0x00010, memory 1-cycle latency returning 0x00000013 -> `mem_read` cycle 1, `i_valid` cycle 3 with `i_data`=0x00000013.
- `i_req` and `d_load` both raised in cycle 0 -> D served first, then I. `i_wait_cycles` ≥ 4 at the end.
- `d_load` held continuously with `i_req` high, STARVE_LIMIT=4 -> 4 D grants, then 1 I grant, then D resumes.
- `d_store` to addr 0x00020, data 0xDEADBEEF -> `mem_write` pulse with `mem_write_data`=0xDEADBEEF; `d_valid` with `d_data`=0.
- Memory never asserts `mem_valid`, TIMEOUT=8 -> response 9 cycles after the command with data 0; `error`=1 and stays 1 until reset.
- `reset` asserted in WAIT_D, then `mem_valid` pulsed 2 cycles later -> no `d_valid`, state IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_I = 2'd1,
        ST_WAIT_D = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Counter snapshot published when a report is requested.
    typedef struct packed {
        logic [7:0]       core;
        logic [CNT_W-1:0] i_grants;
        logic [CNT_W-1:0] d_grants;
        logic [CNT_W-1:0] i_wait_cycles;
    } perf_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side signal bundle for mem_port_arbiter.
// Latency: n/a (wires only).
// Backpressure: level requests held until the one-cycle response pulse.
// master = arbiter side, slave = requesters + memory model.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
);
    logic                    i_req;
    logic [ADDRESS_BITS-1:0] i_addr;
    logic                    i_valid;
    logic [DATA_WIDTH-1:0]   i_data;
    logic                    d_load;
    logic                    d_store;
    logic [ADDRESS_BITS-1:0] d_addr;
    logic [DATA_WIDTH-1:0]   d_store_data;
    logic                    d_valid;
    logic [DATA_WIDTH-1:0]   d_data;
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDRESS_BITS-1:0] mem_address;
    logic [DATA_WIDTH-1:0]   mem_write_data;
    logic [DATA_WIDTH-1:0]   mem_read_data;
    logic                    mem_valid;
    logic                    error;
    logic                    report;
    logic                    report_vld;
    perf_t                   report_dat;

    modport master (
        input  i_req, i_addr, d_load, d_store, d_addr, d_store_data,
               mem_read_data, mem_valid, report,
        output i_valid, i_data, d_valid, d_data, mem_read, mem_write,
               mem_address, mem_write_data, error, report_vld, report_dat
    );

    modport slave (
        output i_req, i_addr, d_load, d_store, d_addr, d_store_data,
               mem_read_data, mem_valid, report,
        input  i_valid, i_data, d_valid, d_data, mem_read, mem_write,
               mem_address, mem_write_data, error, report_vld, report_dat
    );

endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with increment enable and synchronous clear.
// Latency: count updates one cycle after inc.
// Backpressure: none; sticks at all-ones once saturated.
module mem_port_arbiter_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between fetch (I) and load/store (D), one transaction at a time.
// Latency: request -> command 1 cycle -> earliest mem_valid 2 -> response pulse 3; 4 cycles per transaction minimum.
// Backpressure: requests are levels held until their response; D wins unless I has waited STARVE_LIMIT D grants.
// Ports: clock, reset (sync, active-high), bus (master modport: requesters, memory, error, report snapshot).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [3:0] starve_cnt;
    logic       is_store;

    logic                    d_req;
    logic                    grant_d;
    logic                    grant_i;
    logic                    mem_done;
    logic [ADDRESS_BITS-1:0] grant_addr;
    logic [DATA_WIDTH-1:0]   resp_dat;
    logic                    inc_wait;

    logic [CNT_W-1:0] i_grants;
    logic [CNT_W-1:0] d_grants;
    logic [CNT_W-1:0] i_wait_cycles;

    always_comb begin
        d_req      = bus.d_load | bus.d_store;
        grant_d    = (state == ST_IDLE) && d_req &&
                     (!bus.i_req || (starve_cnt < 4'(STARVE_LIMIT)));
        grant_i    = (state == ST_IDLE) && !grant_d && bus.i_req;
        grant_addr = grant_d ? bus.d_addr : bus.i_addr;
        // wait_cnt == 0 marks the command cycle, where mem_valid is not trusted.
        mem_done   = ((state == ST_WAIT_I) || (state == ST_WAIT_D)) && (wait_cnt != 8'd0) &&
                     (bus.mem_valid || (wait_cnt == 8'(TIMEOUT)));
        // A timeout completes with zero data.
        resp_dat   = bus.mem_valid ? bus.mem_read_data : '0;
        // In RESP, i_valid being high is what identifies the I-side response.
        inc_wait   = bus.i_req && !((state == ST_WAIT_I) || ((state == ST_RESP) && bus.i_valid));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= ST_IDLE;
            wait_cnt           <= '0;
            starve_cnt         <= '0;
            is_store           <= 1'b0;
            bus.i_valid        <= 1'b0;
            bus.i_data         <= '0;
            bus.d_valid        <= 1'b0;
            bus.d_data         <= '0;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
            bus.error          <= 1'b0;
            bus.report_vld     <= 1'b0;
            bus.report_dat     <= '0;
        end else begin
            bus.i_valid    <= 1'b0;
            bus.d_valid    <= 1'b0;
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.report_vld <= bus.report;
            if (bus.report) begin
                bus.report_dat <= '{core: 8'(CORE), i_grants: i_grants,
                                    d_grants: d_grants, i_wait_cycles: i_wait_cycles};
            end
            if (bus.d_load && bus.d_store) begin
                bus.error <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (grant_d) begin
                        state              <= ST_WAIT_D;
                        bus.mem_address    <= grant_addr;
                        bus.mem_write_data <= bus.d_store_data;
                        // load+store together is handled as a store.
                        is_store           <= bus.d_store;
                        bus.mem_write      <= bus.d_store;
                        bus.mem_read       <= !bus.d_store;
                        starve_cnt         <= bus.i_req ? starve_cnt + 4'd1 : 4'd0;
                    end else if (grant_i) begin
                        state           <= ST_WAIT_I;
                        bus.mem_address <= grant_addr;
                        is_store        <= 1'b0;
                        bus.mem_read    <= 1'b1;
                        starve_cnt      <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end

                ST_WAIT_I, ST_WAIT_D: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (mem_done) begin
                        state <= ST_RESP;
                        if (!bus.mem_valid) begin
                            bus.error <= 1'b1;
                        end
                        if (state == ST_WAIT_I) begin
                            bus.i_valid <= 1'b1;
                            bus.i_data  <= resp_dat;
                        end else begin
                            bus.d_valid <= 1'b1;
                            bus.d_data  <= is_store ? '0 : resp_dat;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_port_arbiter_sat_counter #(.WIDTH(CNT_W)) u_i_grants (
        .clock (clock), .clr (reset), .inc (grant_i), .count (i_grants)
    );

    mem_port_arbiter_sat_counter #(.WIDTH(CNT_W)) u_d_grants (
        .clock (clock), .clr (reset), .inc (grant_d), .count (d_grants)
    );

    mem_port_arbiter_sat_counter #(.WIDTH(CNT_W)) u_i_wait (
        .clock (clock), .clr (reset), .inc (inc_wait), .count (i_wait_cycles)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single-transaction vector table plus priority,
// starvation, timeout, load+store conflict and mid-transaction reset sequences.
// A behavioural memory answers each command one cycle later unless stalled.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int   checks    = 0;
    int   errors    = 0;
    logic mem_stall = 1'b0;
    int   kick_cnt  = 0;
    int   kick_done = 0;

    mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) bus ();

    mem_port_arbiter #(
        .CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20), .STARVE_LIMIT(4), .TIMEOUT(8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        sel_i;
        logic        ld;
        logic        st;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_data;
    } vec_t;

    function automatic logic [31:0] mem_word(input logic [19:0] a);
        return (a == 20'h00010) ? 32'h00000013 : {12'hA5A, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic outs_nonzero();
        return |{bus.i_valid, bus.i_data, bus.d_valid, bus.d_data, bus.mem_read, bus.mem_write,
                 bus.mem_address, bus.mem_write_data, bus.error, bus.report_vld, bus.report_dat};
    endfunction

    task automatic drop_reqs();
        bus.i_req        = 1'b0;
        bus.i_addr       = '0;
        bus.d_load       = 1'b0;
        bus.d_store      = 1'b0;
        bus.d_addr       = '0;
        bus.d_store_data = '0;
        bus.report       = 1'b0;
    endtask

    // Leaves the caller 1ns into the first cycle after reset is released.
    task automatic do_reset();
        reset = 1'b1;
        drop_reqs();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Called 1ns into a cycle (relative cycle 0); watches for the memory command and
    // the response pulse, and returns 1ns into the cycle after the response.
    task automatic wait_resp(input int max_cyc, output int resp_cyc, output logic was_i,
                             output logic [31:0] data, output int cmd_cyc,
                             output logic [1:0] cmd_op, output logic [19:0] cmd_addr,
                             output logic [31:0] cmd_wdata);
        resp_cyc  = -1;
        cmd_cyc   = -1;
        was_i     = 1'b0;
        data      = '0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clock);
            if ((bus.mem_read || bus.mem_write) && (cmd_cyc < 0)) begin
                cmd_cyc   = k;
                cmd_op    = {bus.mem_read, bus.mem_write};
                cmd_addr  = bus.mem_address;
                cmd_wdata = bus.mem_write_data;
            end
            if (bus.i_valid || bus.d_valid) begin
                resp_cyc = k;
                was_i    = bus.i_valid;
                data     = bus.i_valid ? bus.i_data : bus.d_data;
            end
            @(posedge clock);
            #1;
            if (resp_cyc >= 0) break;
        end
        if (resp_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got no response within %0d cycles, expected one", max_cyc);
        end
    endtask

    // Behavioural memory: one-cycle latency, optional stall, and stale-pulse injection.
    initial begin
        logic [19:0] a;
        bus.mem_valid     = 1'b0;
        bus.mem_read_data = '0;
        forever begin
            @(negedge clock);
            if ((bus.mem_read || bus.mem_write) && !mem_stall) begin
                a = bus.mem_address;
                @(posedge clock);
                #1;
                bus.mem_valid     = 1'b1;
                bus.mem_read_data = mem_word(a);
                @(posedge clock);
                #1;
                bus.mem_valid = 1'b0;
            end else if (kick_cnt != kick_done) begin
                @(posedge clock);
                #1;
                bus.mem_valid     = 1'b1;
                bus.mem_read_data = 32'hBAD0BAD0;
                @(posedge clock);
                #1;
                bus.mem_valid = 1'b0;
                kick_done++;
            end
        end
    end

    always @(negedge clock) begin
        if (bus.report_vld) begin
            $display("core %0d: i_grants=%0d d_grants=%0d i_wait_cycles=%0d",
                     bus.report_dat.core, bus.report_dat.i_grants,
                     bus.report_dat.d_grants, bus.report_dat.i_wait_cycles);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [5];
        int          rc, cc;
        logic        wi, saw_dv;
        logic [31:0] rd, wd;
        logic [1:0]  op;
        logic [19:0] ad;

        //           sel_i ld    st    addr       wdata         rd    wr    data
        vecs[0] = '{1'b1, 1'b0, 1'b0, 20'h00010, 32'h0,        1'b1, 1'b0, 32'h00000013};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 20'h00040, 32'h0,        1'b1, 1'b0, 32'hA5A00040};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 20'h00020, 32'hDEADBEEF, 1'b0, 1'b1, 32'h00000000};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 20'hFFFFF, 32'h0,        1'b1, 1'b0, 32'hA5AFFFFF};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 20'h00000, 32'h0,        1'b1, 1'b0, 32'hA5A00000};

        drop_reqs();
        do_reset();
        @(negedge clock);
        chk("reset_outs_zero", outs_nonzero(), 0);
        chk("reset_state", dut.state, ST_IDLE);
        @(posedge clock);
        #1;

        // Single transactions from the table.
        for (int i = 0; i < 5; i++) begin
            bus.i_req        = vecs[i].sel_i;
            bus.i_addr       = vecs[i].addr;
            bus.d_load       = vecs[i].ld;
            bus.d_store      = vecs[i].st;
            bus.d_addr       = vecs[i].addr;
            bus.d_store_data = vecs[i].wdata;
            wait_resp(20, rc, wi, rd, cc, op, ad, wd);
            chk($sformatf("v%0d_cmd_cycle", i), cc, 1);
            chk($sformatf("v%0d_cmd_op", i), op, {vecs[i].exp_rd, vecs[i].exp_wr});
            chk($sformatf("v%0d_cmd_addr", i), ad, vecs[i].addr);
            if (vecs[i].st) chk($sformatf("v%0d_cmd_wdata", i), wd, vecs[i].wdata);
            chk($sformatf("v%0d_resp_cycle", i), rc, 3);
            chk($sformatf("v%0d_resp_side", i), wi, vecs[i].sel_i);
            chk($sformatf("v%0d_resp_data", i), rd, vecs[i].exp_data);
            drop_reqs();
        end
        chk("table_error_clear", bus.error, 0);

        // Simultaneous I and D: D first, then I; counters via report.
        do_reset();
        bus.i_req  = 1'b1;
        bus.i_addr = 20'h00010;
        bus.d_load = 1'b1;
        bus.d_addr = 20'h00040;
        wait_resp(20, rc, wi, rd, cc, op, ad, wd);
        chk("prio_first_is_d", wi, 0);
        chk("prio_first_cycle", rc, 3);
        chk("prio_first_data", rd, 32'hA5A00040);
        bus.d_load = 1'b0;
        wait_resp(20, rc, wi, rd, cc, op, ad, wd);
        chk("prio_second_is_i", wi, 1);
        chk("prio_second_cycle", rc, 3);
        chk("prio_second_data", rd, 32'h00000013);
        drop_reqs();
        bus.report = 1'b1;
        @(posedge clock);
        #1 bus.report = 1'b0;
        @(negedge clock);
        chk("report_vld", bus.report_vld, 1);
        chk("report_core", bus.report_dat.core, 0);
        chk("report_i_grants", bus.report_dat.i_grants, 1);
        chk("report_d_grants", bus.report_dat.d_grants, 1);
        chk("report_i_wait_ge4", bus.report_dat.i_wait_cycles >= 4, 1);
        @(posedge clock);
        #1;

        // Starvation bound: D,D,D,D,I,D with both requests held.
        do_reset();
        bus.i_req  = 1'b1;
        bus.i_addr = 20'h00010;
        bus.d_load = 1'b1;
        bus.d_addr = 20'h00040;
        for (int n = 0; n < 6; n++) begin
            wait_resp(20, rc, wi, rd, cc, op, ad, wd);
            chk($sformatf("starve_side_%0d", n), wi, (n == 4));
            chk($sformatf("starve_spacing_%0d", n), rc, 3);
        end
        drop_reqs();

        // Timeout: memory never answers.
        do_reset();
        mem_stall  = 1'b1;
        bus.d_load = 1'b1;
        bus.d_addr = 20'h00060;
        wait_resp(40, rc, wi, rd, cc, op, ad, wd);
        chk("to_cmd_cycle", cc, 1);
        chk("to_resp_after_cmd", rc - cc, 9);
        chk("to_resp_is_d", wi, 0);
        chk("to_resp_data", rd, 0);
        chk("to_error_set", bus.error, 1);
        drop_reqs();
        mem_stall  = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 20'h00010;
        wait_resp(20, rc, wi, rd, cc, op, ad, wd);
        chk("to_next_data", rd, 32'h00000013);
        chk("to_error_sticky", bus.error, 1);
        drop_reqs();

        // Load and store together: performed as a store, error flagged.
        do_reset();
        bus.d_load       = 1'b1;
        bus.d_store      = 1'b1;
        bus.d_addr       = 20'h00030;
        bus.d_store_data = 32'h12345678;
        wait_resp(20, rc, wi, rd, cc, op, ad, wd);
        chk("both_cmd_op", op, 2'b01);
        chk("both_cmd_wdata", wd, 32'h12345678);
        chk("both_resp_data", rd, 0);
        chk("both_error", bus.error, 1);
        drop_reqs();

        // Reset while in WAIT_D, then a stale mem_valid.
        do_reset();
        mem_stall  = 1'b1;
        bus.d_load = 1'b1;
        bus.d_addr = 20'h00050;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_mid_in_wait_d", dut.state, ST_WAIT_D);
        reset      = 1'b1;
        bus.d_load = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        kick_cnt++;
        saw_dv = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (bus.d_valid || bus.i_valid) saw_dv = 1'b1;
        end
        chk("rst_mid_no_resp", saw_dv, 0);
        chk("rst_mid_state", dut.state, ST_IDLE);
        chk("rst_mid_outs_zero", outs_nonzero(), 0);
        mem_stall = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
